// File: rtl/hamm_encoder_stream_if.sv
// Stream, error-injection and status signals of the Hamming (8,4) encoder.
// Master = upstream/downstream test side, slave = encoder.
interface hamm_encoder_stream_if #(
  parameter int CNT_W = 16
);
  logic [3:0]       in_data;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       out_code;
  logic             out_valid;
  logic             out_ready;
  logic             inj_req;
  logic [2:0]       inj_pos;
  logic             inj_armed;
  logic [CNT_W-1:0] code_cnt;

  modport master (
    output in_data, in_valid, out_ready, inj_req, inj_pos,
    input  in_ready, out_code, out_valid, inj_armed, code_cnt
  );

  modport slave (
    input  in_data, in_valid, out_ready, inj_req, inj_pos,
    output in_ready, out_code, out_valid, inj_armed, code_cnt
  );
endinterface

// File: rtl/hamm_encoder_stream.sv
// Streaming extended Hamming (8,4) encoder with an output FIFO, a one-shot
// single-bit error injector and a wrapping count of codewords written.
// Codeword layout: c[7:4]=d, c[3]=d3^d2^d1, c[2]=d3^d2^d0, c[1]=d3^d1^d0,
// c[0]=even parity over c[7:1].
module hamm_encoder_stream #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  hamm_encoder_stream_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  // Pointers carry an extra wrap bit so full and empty can be told apart.
  logic [AW:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DEPTH-1:0][7:0]  mem_q, mem_d;
  logic                   in_ready_q, in_ready_d;
  logic                   inj_armed_q, inj_armed_d;
  logic [2:0]             inj_pos_q, inj_pos_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;

  logic       empty, push, pop, full_n;
  logic [7:0] code_w;

  function automatic logic [7:0] encode(input logic [3:0] d);
    logic [7:0] c;
    c[7:4] = d;
    c[3]   = d[3] ^ d[2] ^ d[1];
    c[2]   = d[3] ^ d[2] ^ d[0];
    c[1]   = d[3] ^ d[1] ^ d[0];
    c[0]   = ^c[7:1];
    return c;
  endfunction

  assign empty = (wr_ptr_q == rd_ptr_q);

  // Next-state: FIFO push/pop, injection arm/apply, counter, registered ready.
  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    inj_armed_d = inj_armed_q;
    inj_pos_d   = inj_pos_q;
    cnt_d       = cnt_q;

    // in_ready_q is exactly !full, so a push never overruns the FIFO.
    push   = bus.in_valid && in_ready_q;
    pop    = !empty && bus.out_ready;
    code_w = encode(bus.in_data) ^ (inj_armed_q ? (8'd1 << inj_pos_q) : 8'd0);

    if (push) begin
      mem_d[wr_ptr_q[AW-1:0]] = code_w;
      wr_ptr_d    = wr_ptr_q + (AW+1)'(1);
      cnt_d       = cnt_q + CNT_W'(1);
      inj_armed_d = 1'b0;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);

    // A request in the same cycle as an accept arms for the next accept.
    if (bus.inj_req) begin
      inj_armed_d = 1'b1;
      inj_pos_d   = bus.inj_pos;
    end

    full_n     = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                 (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    in_ready_d = !full_n;
  end

  // State registers; reset empties the FIFO and drops any pending injection.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      in_ready_q  <= 1'b0;
      inj_armed_q <= 1'b0;
      inj_pos_q   <= '0;
      cnt_q       <= '0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      inj_armed_q <= inj_armed_d;
      inj_pos_q   <= inj_pos_d;
      cnt_q       <= cnt_d;
    end
  end

  // Head word comes straight from FIFO storage, never from in_data.
  assign bus.out_code  = mem_q[rd_ptr_q[AW-1:0]];
  assign bus.out_valid = !empty;
  assign bus.in_ready  = in_ready_q;
  assign bus.inj_armed = inj_armed_q;
  assign bus.code_cnt  = cnt_q;
endmodule

// File: tb/tb_hamm_encoder_stream.sv
// Directed bench for hamm_encoder_stream. Inputs change and outputs are
// sampled on the falling edge; the design acts on the rising edge.
module tb_hamm_encoder_stream;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  hamm_encoder_stream_if #(.CNT_W(16)) bus ();
  hamm_encoder_stream_if #(.CNT_W(4))  bus4 ();

  hamm_encoder_stream #(.DEPTH(4), .CNT_W(16)) dut  (.clk(clk), .reset(reset), .bus(bus.slave));
  hamm_encoder_stream #(.DEPTH(4), .CNT_W(4))  dut4 (.clk(clk), .reset(reset), .bus(bus4.slave));

  // Narrow-counter instance mirrors the main stimulus.
  assign bus4.in_data   = bus.in_data;
  assign bus4.in_valid  = bus.in_valid;
  assign bus4.out_ready = bus.out_ready;
  assign bus4.inj_req   = bus.inj_req;
  assign bus4.inj_pos   = bus.inj_pos;

  function automatic logic [7:0] enc(input logic [3:0] d);
    logic [7:0] c;
    c[7:4] = d;
    c[3]   = d[3] ^ d[2] ^ d[1];
    c[2]   = d[3] ^ d[2] ^ d[0];
    c[1]   = d[3] ^ d[1] ^ d[0];
    c[0]   = ^c[7:1];
    return c;
  endfunction

  // Decoder-side syndrome: three parity checks plus overall parity.
  function automatic logic [3:0] syndrome(input logic [7:0] c);
    logic [3:0] s;
    s[2] = c[3] ^ c[7] ^ c[6] ^ c[5];
    s[1] = c[2] ^ c[7] ^ c[6] ^ c[4];
    s[0] = c[1] ^ c[7] ^ c[5] ^ c[4];
    s[3] = ^c;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [3:0] fill_tab [6];
  logic [3:0] q [$];
  logic [3:0] nib;

  initial begin
    fill_tab[0] = 4'h3; fill_tab[1] = 4'h5; fill_tab[2] = 4'hA;
    fill_tab[3] = 4'hC; fill_tab[4] = 4'h7; fill_tab[5] = 4'h9;
    bus.in_data = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.inj_req = 1'b0; bus.inj_pos = '0;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_in_ready",  32'(bus.in_ready), 0);
    chk("rst_out_code",  32'(bus.out_code), 0);
    chk("rst_cnt",       32'(bus.code_cnt), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    chk("rdy_after_rst", 32'(bus.in_ready), 1);

    // Encoding sequence, one word visible the cycle after accept
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'h0;
    @(negedge clk); chk("enc_0", 32'(bus.out_code), 32'h00); chk("enc_v", 32'(bus.out_valid), 1);
    bus.in_data = 4'h1;
    @(negedge clk); chk("enc_1", 32'(bus.out_code), 32'h17);
    bus.in_data = 4'hB;
    @(negedge clk); chk("enc_b", 32'(bus.out_code), 32'hB2);
    bus.in_data = 4'hF;
    @(negedge clk); chk("enc_f", 32'(bus.out_code), 32'hFF);
    bus.in_valid = 1'b0;
    chk("enc_cnt", 32'(bus.code_cnt), 4);
    @(negedge clk); chk("enc_drained", 32'(bus.out_valid), 0);

    // Fill with out_ready low: only DEPTH words go in, no write-through
    bus.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("fill_rdy%0d", i), 32'(bus.in_ready), (i < 4) ? 1 : 0);
      bus.in_valid = 1'b1; bus.in_data = fill_tab[i];
      if (i == 5) bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
    end
    // The last step had out_ready=1 while full: one pop, no push.
    bus.in_valid = 1'b0;
    chk("fill_cnt", 32'(bus.code_cnt), 8);
    chk("fill_rdy_back", 32'(bus.in_ready), 1);
    for (int i = 1; i < 4; i++) begin
      chk($sformatf("drain%0d", i), 32'(bus.out_code), 32'(enc(fill_tab[i])));
      // Stall one cycle on the first drained word: head must hold.
      if (i == 1) begin
        @(negedge clk);
        chk("hold_code", 32'(bus.out_code), 32'(enc(fill_tab[1])));
      end
      bus.out_ready = 1'b1;
      @(negedge clk);
    end
    chk("drain_empty", 32'(bus.out_valid), 0);

    // Concurrent push/pop, 100 random nibbles
    bus.in_valid = 1'b1;
    for (int i = 0; i < 101; i++) begin
      if (i > 0) begin
        nib = q.pop_front();
        chk("cc_valid", 32'(bus.out_valid), 1);
        chk("cc_code", 32'(bus.out_code), 32'(enc(nib)));
        chk("cc_synd", 32'(syndrome(bus.out_code)), 0);
      end
      if (i < 100) begin
        bus.in_data = 4'($urandom_range(0, 15));
        q.push_back(bus.in_data);
      end else
        bus.in_valid = 1'b0;
      @(negedge clk);
    end
    chk("cc_cnt", 32'(bus.code_cnt), 108);
    chk("cc_empty", 32'(bus.out_valid), 0);

    // Injection on bit 5, then clean word
    bus.inj_req = 1'b1; bus.inj_pos = 3'd5;
    @(negedge clk);
    bus.inj_req = 1'b0;
    chk("inj_armed", 32'(bus.inj_armed), 1);
    bus.in_valid = 1'b1; bus.in_data = 4'hB;
    @(negedge clk);
    chk("inj_code", 32'(bus.out_code), 32'h92);
    chk("inj_clear", 32'(bus.inj_armed), 0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("inj_clean", 32'(bus.out_code), 32'hB2);
    chk("inj_cnt", 32'(bus.code_cnt), 110);

    // Same-cycle request arms for the following accept
    bus.inj_req = 1'b1; bus.inj_pos = 3'd0;
    bus.in_valid = 1'b1; bus.in_data = 4'h1;
    @(negedge clk);
    bus.inj_req = 1'b0;
    chk("sc_first", 32'(bus.out_code), 32'h17);
    chk("sc_armed", 32'(bus.inj_armed), 1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    chk("sc_second", 32'(bus.out_code), 32'h16);
    chk("sc_clear", 32'(bus.inj_armed), 0);
    @(negedge clk);

    // Re-arm overwrites position; single flip only
    bus.inj_req = 1'b1; bus.inj_pos = 3'd7;
    @(negedge clk); bus.inj_pos = 3'd2;
    @(negedge clk); bus.inj_req = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'hF;
    @(negedge clk); chk("rearm_code", 32'(bus.out_code), 32'hFB);
    @(negedge clk); bus.in_valid = 1'b0;
    chk("rearm_once", 32'(bus.out_code), 32'hFF);
    @(negedge clk);

    // Reset mid-operation with words buffered and injection armed
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 4'h2;
    repeat (3) @(negedge clk);
    bus.in_valid = 1'b0;
    bus.inj_req = 1'b1; bus.inj_pos = 3'd1;
    @(negedge clk); bus.inj_req = 1'b0;
    chk("pre_rst_armed", 32'(bus.inj_armed), 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.out_valid), 0);
    chk("mid_rst_cnt",   32'(bus.code_cnt), 0);
    chk("mid_rst_armed", 32'(bus.inj_armed), 0);
    chk("mid_rst_rdy",   32'(bus.in_ready), 0);
    @(negedge clk); reset = 1'b1;
    @(negedge clk);

    // 17 words: 16-bit counter reads 17, 4-bit counter wraps to 1
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 4'h6;
    repeat (17) @(negedge clk);
    bus.in_valid = 1'b0;
    chk("wrap_cnt16", 32'(bus.code_cnt), 17);
    chk("wrap_cnt4",  32'(bus4.code_cnt), 1);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Cycle budget guard
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
